kernel_nios2_cpu_debug_cmd_sched: RTL and testbench
===================================================

// Module: kernel_nios2_cpu_debug_cmd_sched
// PURPOSE
//  System-clock sequencer for the Nios II JTAG debug slave's OCI memory actions.
//  Turns the take_action_ocimem_* / take_no_action_ocimem_a strobes and jdo payload
//  into a queued stream of single-beat read/write requests to the on-chip debug memory.
//  Returns read data in MonDReg and status in monitor_ready / monitor_error.
//  Sits between the debug slave sysclk logic and the OCI debug RAM port.
// PARAMETERS
//  ADDR_W          8    debug memory word-address width; jdo[ADDR_W+16:17] carries the address
//  FIFO_DEPTH      4    command queue depth; must be a power of 2 and >= 2
//  TIMEOUT_CYCLES  255  maximum cycles in REQ before abort (used only with the timeout macro)
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       asynchronous reset, active-low
//  jdo                      in   38      debug slave payload
//  take_action_ocimem_a     in   1       load address; optional read; optional error clear
//  take_action_ocimem_b     in   1       write jdo[34:3] at the current address
//  take_no_action_ocimem_a  in   1       read at the current address
//  debugack                 in   1       CPU is halted in debug mode
//  mem_req                  out  1       memory request, held until mem_ack
//  mem_we                   out  1       1 = write, 0 = read
//  mem_addr                 out  ADDR_W  word address
//  mem_wdata                out  32      write data
//  mem_ack                  in   1       one-cycle completion strobe
//  mem_rdata                in   32      read data, valid with mem_ack
//  mem_err                  in   1       access error, valid with mem_ack
//  MonDReg                  out  32      last read data
//  monitor_ready            out  1       queue empty and FSM IDLE
//  monitor_error            out  1       sticky error flag
// BEHAVIOUR
//  Enqueue side
//  - Each entry is {we, addr, wdata}. cmd_addr is the enqueue-side pointer.
//  - ocimem_a: cmd_addr<=jdo[ADDR_W+16:17].
//      If jdo[35]=1, also enqueue a read at that address; cmd_addr<=addr+1.
//      If jdo[36]=1, clear monitor_error.
//  - ocimem_b: enqueue write(cmd_addr, jdo[34:3]); cmd_addr++.
//  - no_action_ocimem_a: enqueue read(cmd_addr); cmd_addr++.
//  - Priority when strobes coincide: ocimem_a > ocimem_b > no_action_ocimem_a.
//  - cmd_addr wraps mod 2^ADDR_W (0xFF+1 -> 0x00).
//  - Queue full (push without a same-cycle pop): command is dropped, cmd_addr is held,
//    and monitor_error is set. Push and pop in the same cycle when full is accepted.
//  - Write with debugack=0: not enqueued, cmd_addr is held, monitor_error is set.
//    Reads are allowed with debugack=0.
//  Issue FSM (IDLE, REQ)
//  - IDLE: if the queue is non-empty, go to REQ and register the head entry onto mem_*.
//  - REQ: mem_req=1, mem_* stable until mem_ack.
//      On mem_ack: pop; read => MonDReg<=mem_rdata; mem_err => monitor_error set; go IDLE.
//  - Minimum latency: enqueue at cycle 0 -> mem_req at 1; ack at 1 -> MonDReg/ready at 2.
//  - One IDLE bubble between consecutive requests.
//  Status
//  - monitor_ready is combinational: (queue empty && state==IDLE). It drops the cycle
//    after an enqueue.
//  - monitor_error: set and clear in the same cycle => set wins.
//  Reset
//  - Asynchronous, mid-operation: queue flushed, FSM to IDLE, mem_req deasserts at once.
//  - Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MonDReg=0,
//    monitor_error=0, monitor_ready=1, cmd_addr=0.
// CONFIGURATION
//  KERNEL_DBG_SCHED_TIMEOUT_EN defined:
//  - A counter runs in REQ. After TIMEOUT_CYCLES cycles without mem_ack: drop mem_req,
//    pop the entry, set monitor_error, leave MonDReg unchanged, go IDLE.
//  - A late mem_ack arriving in IDLE is ignored.
//  Not defined: no counter; REQ waits for mem_ack indefinitely.
// TESTING
//  1 ocimem_a jdo[24:17]=0x10, jdo[35]=1; mem_ack next cycle with rdata=0xCAFEF00D
//    -> mem_addr=0x10, mem_we=0; MonDReg=0xCAFEF00D; monitor_ready=1 two cycles after strobe.
//  2 debugack=1, ocimem_a addr 0xFF; then two ocimem_b writes 0x1, 0x2
//    -> writes issued to 0xFF then 0x00 (wrap); MonDReg unchanged.
//  3 mem_ack held off; 5 read strobes with FIFO_DEPTH=4
//    -> 4 accepted, 5th dropped, monitor_error=1.
//    Then ocimem_a with jdo[36]=1 -> error cleared.
//  4 ocimem_b with debugack=0 -> no mem_req, monitor_error=1, cmd_addr unchanged.
//  5 With TIMEOUT_EN, never ack -> mem_req drops after 255 cycles, monitor_error=1, ready=1.
//    Without TIMEOUT_EN -> mem_req still high after 1000 cycles.
//  6 reset_n low while in REQ with 3 queued -> mem_req=0 immediately.
//    After release: monitor_ready=1 and no further requests.

Source files
------------

// File: rtl/kernel_nios2_cpu_debug_cmd_sched.sv
// Nios II debug-slave OCI memory command scheduler: queues jdo-driven reads/writes and issues them singly.
// Optional REQ watchdog: define KERNEL_DBG_SCHED_TIMEOUT_EN.
module kernel_nios2_cpu_debug_cmd_sched #(
  parameter int ADDR_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic              err_q, err_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              timeout_hit;

  logic              push_req;
  logic              push_ok;
  logic              push_we;
  logic [ADDR_W-1:0] push_addr;
  logic [31:0]       push_wdata;
  logic [ENT_W-1:0]  push_entry;
  logic              err_set_enq;
  logic              err_set_fsm;
  logic              err_clr;

  logic [ENT_W-1:0]  head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_wdata;
  logic [ADDR_W-1:0] jdo_addr;

  logic              unused_jdo_bits;

  assign jdo_addr        = jdo[ADDR_W+16:17];
  assign unused_jdo_bits = ^{jdo[37], jdo[2:0]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // The head entry stays queued while it is on the bus; it leaves only on completion.
  assign pop = (state_q == ST_REQ) && (mem_ack || timeout_hit);

  assign head       = fifo_q[rd_ptr_q];
  assign head_we    = head[ENT_W-1];
  assign head_addr  = head[ENT_W-2 -: ADDR_W];
  assign head_wdata = head[31:0];
  assign push_entry = {push_we, push_addr, push_wdata};

  // Enqueue side: decode strobes by priority, then accept or drop.
  always_comb begin
    push_req    = 1'b0;
    push_we     = 1'b0;
    push_addr   = cmd_addr_q;
    push_wdata  = '0;
    err_set_enq = 1'b0;
    err_clr     = 1'b0;
    cmd_addr_d  = cmd_addr_q;

    if (take_action_ocimem_a) begin
      cmd_addr_d = jdo_addr;
      err_clr    = jdo[36];
      if (jdo[35]) begin
        push_req  = 1'b1;
        push_addr = jdo_addr;
      end
    end else if (take_action_ocimem_b) begin
      if (debugack) begin
        push_req   = 1'b1;
        push_we    = 1'b1;
        push_wdata = jdo[34:3];
      end else begin
        err_set_enq = 1'b1;
      end
    end else if (take_no_action_ocimem_a) begin
      push_req = 1'b1;
    end

    push_ok = push_req && (!fifo_full || pop);
    if (push_req && !push_ok) begin
      err_set_enq = 1'b1;
    end
    if (push_ok) begin
      cmd_addr_d = push_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  // Issue FSM; an empty queue can launch straight from the incoming entry.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mondreg_d   = mondreg_q;
    err_set_fsm = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d     = ST_REQ;
          mem_we_d    = head_we;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_wdata;
        end else if (push_ok) begin
          state_d     = ST_REQ;
          mem_we_d    = push_we;
          mem_addr_d  = push_addr;
          mem_wdata_d = push_wdata;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d     = ST_IDLE;
          err_set_fsm = mem_err;
          if (!mem_we_q) begin
            mondreg_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          err_set_fsm = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_set_enq || err_set_fsm) begin
      err_d = 1'b1;
    end
  end

`ifdef KERNEL_DBG_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (state_q == ST_REQ) && !mem_ack &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_REQ) && !mem_ack && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo_cfg;

  assign timeout_hit    = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mondreg_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mondreg_q   <= mondreg_d;
      err_q       <= err_d;
    end
  end

  assign mem_req       = (state_q == ST_REQ);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign MonDReg       = mondreg_q;
  assign monitor_error = err_q;
  assign monitor_ready = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_kernel_nios2_cpu_debug_cmd_sched.sv
// Scenario bench for the debug command scheduler: expected bus requests are queued at stimulus time.
module tb_kernel_nios2_cpu_debug_cmd_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic        debugack;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_mon = '0;

  always #5 clk = ~clk;

  kernel_nios2_cpu_debug_cmd_sched dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_ack                 (mem_ack),
    .mem_rdata               (mem_rdata),
    .mem_err                 (mem_err),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    j[34:3] = wd;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    jdo = j;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic do_ack(input logic [31:0] rd, input logic err);
    mem_ack = 1'b1;
    mem_rdata = rd;
    mem_err = err;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, MonDReg, monitor_error, monitor_ready} !== {2'b00, 8'h00, 32'h0, 32'h0, 2'b01}) begin
      bad++;
      $display("FAIL reset_vals got req=%0b we=%0b addr=%02h wd=%08h mon=%08h err=%0b rdy=%0b want 0 0 00 0 0 0 1",
               mem_req, mem_we, mem_addr, mem_wdata, MonDReg, monitor_error, monitor_ready);
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    exp_mon = '0;
    sb.push_back('{we: 1'b0, addr: 8'h00, wdata: 32'h0, rdata: 32'h1234_0000});
    strobe(1'b0, 1'b0, 1'b1, '0);
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL reset_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("reset: req we=%0b addr=%02h wd=%08h", mem_we, mem_addr, mem_wdata);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL reset_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
  endtask

  task automatic test_read_basic();
    exp_t e;
    bit   ok;
    sb.push_back('{we: 1'b0, addr: 8'h10, wdata: 32'h0, rdata: 32'hCAFE_F00D});
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
    total++;
    if (mem_req !== 1'b1 || monitor_ready !== 1'b0) begin
      bad++;
      $display("FAIL read_latency got req=%0b rdy=%0b want req=1 rdy=0", mem_req, monitor_ready);
    end
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL read_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("read_basic: req we=%0b addr=%02h", mem_we, mem_addr);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon || monitor_ready !== 1'b1) begin
        bad++;
        $display("FAIL read_done got mon=%08h rdy=%0b want mon=%08h rdy=1", MonDReg, monitor_ready, exp_mon);
      end
    end
  endtask

  task automatic test_write_wrap();
    exp_t e;
    bit   ok;
    debugack = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0, 1'b0));
    sb.push_back('{we: 1'b1, addr: 8'hFF, wdata: 32'h1, rdata: 32'h1111_1111});
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h1));
    sb.push_back('{we: 1'b1, addr: 8'h00, wdata: 32'h2, rdata: 32'h2222_2222});
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h2));
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL wrap_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("write_wrap: req we=%0b addr=%02h wd=%08h", mem_we, mem_addr, mem_wdata);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL wrap_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
    total++;
    if (monitor_error !== 1'b0) begin
      bad++;
      $display("FAIL wrap_err got %0b want 0", monitor_error);
    end
  endtask

  task automatic test_queue_full();
    exp_t e;
    bit   ok;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h20, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back('{we: 1'b0, addr: 8'h20 + 8'(i), wdata: 32'h0, rdata: 32'hA000_0000 + 32'(i)});
      strobe(1'b0, 1'b0, 1'b1, '0);
    end
    total++;
    if (monitor_error !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 8'h20) begin
      bad++;
      $display("FAIL full_drop got err=%0b req=%0b addr=%02h want err=1 req=1 addr=20", monitor_error, mem_req, mem_addr);
    end
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h30, 1'b0, 1'b1));
    total++;
    if (monitor_error !== 1'b0) begin
      bad++;
      $display("FAIL full_clear got err=%0b want 0", monitor_error);
    end
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL full_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("queue_full: req we=%0b addr=%02h", mem_we, mem_addr);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL full_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
    total++;
    if (mem_req !== 1'b0 || monitor_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_drained got req=%0b rdy=%0b want req=0 rdy=1", mem_req, monitor_ready);
    end
  endtask

  task automatic test_write_no_debugack();
    exp_t e;
    bit   ok;
    bit   seen_req;
    debugack = 1'b0;
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h55));
    seen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req !== 1'b0) seen_req = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen_req || monitor_error !== 1'b1) begin
      bad++;
      $display("FAIL nodbg_write got req_seen=%0b err=%0b want req_seen=0 err=1", seen_req, monitor_error);
    end
    debugack = 1'b1;
    sb.push_back('{we: 1'b0, addr: 8'h30, wdata: 32'h0, rdata: 32'h3030_3030});
    strobe(1'b0, 1'b0, 1'b1, '0);
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL nodbg_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("write_no_debugack: req we=%0b addr=%02h", mem_we, mem_addr);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL nodbg_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b0, 1'b1));
    total++;
    if (monitor_error !== 1'b0) begin
      bad++;
      $display("FAIL nodbg_clear got err=%0b want 0", monitor_error);
    end
  endtask

  task automatic test_priority();
    exp_t        e;
    bit          ok;
    logic [37:0] j;
    sb.push_back('{we: 1'b0, addr: 8'h50, wdata: 32'h0, rdata: 32'h5050_0000});
    strobe(1'b1, 1'b1, 1'b1, jdo_a(8'h50, 1'b1, 1'b0));
    sb.push_back('{we: 1'b0, addr: 8'h51, wdata: 32'h0, rdata: 32'h5151_0000});
    strobe(1'b0, 1'b0, 1'b1, '0);
    sb.push_back('{we: 1'b1, addr: 8'h52, wdata: 32'h0BAD_CAFE, rdata: 32'h5252_0000});
    j = jdo_b(32'h0BAD_CAFE);
    strobe(1'b0, 1'b1, 1'b1, j);
    sb.push_back('{we: 1'b0, addr: 8'h53, wdata: 32'h0, rdata: 32'h5353_0000});
    strobe(1'b0, 1'b0, 1'b1, '0);
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL prio_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("priority: req we=%0b addr=%02h wd=%08h", mem_we, mem_addr, mem_wdata);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL prio_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
    total++;
    if (monitor_ready !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL prio_extra got rdy=%0b req=%0b want rdy=1 req=0", monitor_ready, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    sb.push_back('{we: 1'b0, addr: 8'h54, wdata: 32'h0, rdata: 32'h5454_5454});
    sb.push_back('{we: 1'b0, addr: 8'h55, wdata: 32'h0, rdata: 32'h5555_5555});
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b0, 1'b1, '0);
    wait_req(ok);
    e = sb.pop_front();
    total++;
    if (!ok || mem_addr !== e.addr || mem_we !== e.we) begin
      bad++;
      $display("FAIL b2b_first got req=%0b we=%0b addr=%02h want we=%0b addr=%02h", mem_req, mem_we, mem_addr, e.we, e.addr);
    end else $display("back_to_back: req we=%0b addr=%02h", mem_we, mem_addr);
    do_ack(e.rdata, 1'b0);
    exp_mon = e.rdata;
    total++;
    if (mem_req !== 1'b0 || MonDReg !== exp_mon) begin
      bad++;
      $display("FAIL b2b_bubble got req=%0b mon=%08h want req=0 mon=%08h", mem_req, MonDReg, exp_mon);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_we !== e.we) begin
      bad++;
      $display("FAIL b2b_second got req=%0b we=%0b addr=%02h want req=1 we=%0b addr=%02h", mem_req, mem_we, mem_addr, e.we, e.addr);
    end else $display("back_to_back: req we=%0b addr=%02h", mem_we, mem_addr);
    // Error-response ack coincides with an error-clear strobe: the set must win.
    mem_ack = 1'b1;
    mem_err = 1'b1;
    mem_rdata = e.rdata;
    take_action_ocimem_a = 1'b1;
    jdo = jdo_a(8'h60, 1'b0, 1'b1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_rdata = '0;
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    exp_mon = e.rdata;
    total++;
    if (monitor_error !== 1'b1 || MonDReg !== exp_mon || monitor_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_err_set_wins got err=%0b mon=%08h rdy=%0b want err=1 mon=%08h rdy=1",
               monitor_error, MonDReg, monitor_ready, exp_mon);
    end
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h60, 1'b0, 1'b1));
    total++;
    if (monitor_error !== 1'b0) begin
      bad++;
      $display("FAIL b2b_clear got err=%0b want 0", monitor_error);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    int   cnt;
`ifdef KERNEL_DBG_SCHED_TIMEOUT_EN
    strobe(1'b0, 1'b0, 1'b1, '0);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 2000) begin
      cnt++;
      @(posedge clk); #1;
    end
    total++;
    if (cnt != 255 || monitor_error !== 1'b1 || monitor_ready !== 1'b1 || MonDReg !== exp_mon) begin
      bad++;
      $display("FAIL timeout_abort got cycles=%0d err=%0b rdy=%0b mon=%08h want cycles=255 err=1 rdy=1 mon=%08h",
               cnt, monitor_error, monitor_ready, MonDReg, exp_mon);
    end else $display("timeout: req aborted after %0d cycles", cnt);
    strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h61, 1'b0, 1'b1));
    do_ack(32'hDEAD_DEAD, 1'b1);
    total++;
    if (monitor_error !== 1'b0 || MonDReg !== exp_mon || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_late_ack got err=%0b mon=%08h req=%0b want err=0 mon=%08h req=0",
               monitor_error, MonDReg, mem_req, exp_mon);
    end
`else
    sb.push_back('{we: 1'b0, addr: 8'h60, wdata: 32'h0, rdata: 32'h6060_6060});
    strobe(1'b0, 1'b0, 1'b1, '0);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (mem_req !== 1'b1) cnt++;
      @(posedge clk); #1;
    end
    total++;
    if (cnt != 0 || mem_req !== 1'b1 || monitor_error !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout got low_cycles=%0d req=%0b err=%0b want low_cycles=0 req=1 err=0", cnt, mem_req, monitor_error);
    end
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL notmo_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("timeout: req we=%0b addr=%02h still held", mem_we, mem_addr);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL notmo_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    bit   seen_req;
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b0, 1'b1, '0);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got req=%0b want 1", mem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || monitor_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async got req=%0b rdy=%0b want req=0 rdy=1", mem_req, monitor_ready);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    exp_mon = '0;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b0 || monitor_ready !== 1'b1) seen_req = 1'b1;
    end
    total++;
    if (seen_req || MonDReg !== exp_mon) begin
      bad++;
      $display("FAIL rstmid_after got stray=%0b mon=%08h want stray=0 mon=%08h", seen_req, MonDReg, exp_mon);
    end
    sb.push_back('{we: 1'b0, addr: 8'h00, wdata: 32'h0, rdata: 32'h7777_0000});
    strobe(1'b0, 1'b0, 1'b1, '0);
    while (sb.size() > 0) begin
      wait_req(ok);
      e = sb.pop_front();
      total++;
      if (!ok || {mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
        bad++;
        $display("FAIL rstmid_req got req=%0b we=%0b addr=%02h wd=%08h want we=%0b addr=%02h wd=%08h",
                 mem_req, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
      end else $display("reset_mid: req we=%0b addr=%02h", mem_we, mem_addr);
      do_ack(e.rdata, 1'b0);
      if (!e.we) exp_mon = e.rdata;
      total++;
      if (MonDReg !== exp_mon) begin
        bad++;
        $display("FAIL rstmid_mondreg got %08h want %08h", MonDReg, exp_mon);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    debugack = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    test_reset();
    test_read_basic();
    test_write_wrap();
    test_queue_full();
    test_write_no_debugack();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
